// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state type, and the ALU-code to muldiv-op mapping used by
// the decode/EX glue.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,  // signed multiply
    MD_MULTU = 2'b01,  // unsigned multiply
    MD_DIV   = 2'b10,  // signed divide
    MD_DIVU  = 2'b11   // unsigned divide
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } md_state_e;

  // ALU decoder codes; only the four muldiv codes are meaningful here.
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SIGNED_MULT,
    ALU_UNSIGNED_MULT,
    ALU_SIGNED_DIV,
    ALU_UNSIGNED_DIV
  } alu_op_e;

  function automatic md_op_e alu_to_md_op(input alu_op_e alu_op);
    case (alu_op)
      ALU_UNSIGNED_MULT: return MD_MULTU;
      ALU_SIGNED_DIV:    return MD_DIV;
      ALU_UNSIGNED_DIV:  return MD_DIVU;
      default:           return MD_MULT;
    endcase
  endfunction

  // The encoding puts "divide" in bit 1 and "unsigned" in bit 0.
  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation. Used for operand abs() at start
// and for sign correction of the product, quotient and remainder.
//   val_i : value to correct
//   neg_i : 1 = negate, 0 = pass through
//   val_o : corrected value
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: one bit per cycle,
// shift-add multiply and restoring divide on magnitudes, sign fix in FINISH.
// WIDTH must be >= 4 and even.
//   clk, rst       : clock, synchronous active-high reset
//   start_i        : request, accepted only when idle and not flushed
//   op_i, a_i, b_i : operation and operands, sampled with start_i
//   flush_i        : abort any in-flight operation, drops a same-cycle start
//   busy_o         : operation in flight (registered)
//   done_o         : one-cycle pulse, hi_o/lo_o carry the new result
//   hi_o, lo_o     : MULT upper/lower product; DIV remainder/quotient
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e            state_q, state_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  // opa: multiplicand, or dividend shifting into quotient (raw a on /0).
  // opb: multiplier shifting right, or divisor.
  logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
  // Product accumulator; its low WIDTH+1 bits are the divide remainder.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic                 is_div_q, is_div_d, dz_q, dz_d;

  md_op_e               op;
  logic                 op_signed;
  logic [WIDTH-1:0]     a_abs, b_abs, quot_fix, rem_fix;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic                 div_ge;

  assign op        = md_op_e'(op_i);
  assign op_signed = md_is_signed(op);

  muldiv_signfix #(.W(WIDTH)) u_abs_a (
    .val_i(a_i), .neg_i(op_signed & a_i[WIDTH-1]), .val_o(a_abs));
  muldiv_signfix #(.W(WIDTH)) u_abs_b (
    .val_i(b_i), .neg_i(op_signed & b_i[WIDTH-1]), .val_o(b_abs));
  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .val_i(acc_q), .neg_i(neg_res_q), .val_o(prod_fix));
  muldiv_signfix #(.W(WIDTH)) u_fix_quot (
    .val_i(opa_q), .neg_i(neg_res_q), .val_o(quot_fix));
  muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .val_i(acc_q[WIDTH-1:0]), .neg_i(neg_rem_q), .val_o(rem_fix));

  // Multiply step: add multiplicand into the upper half, shift right.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (opb_q[0] ? opa_q : {WIDTH{1'b0}})};

  // Restoring divide step. A set acc_q[WIDTH] means the shifted remainder
  // already exceeds any divisor; the subtraction stays exact modulo
  // 2^(WIDTH+1) because the true result is below the divisor.
  assign div_shift = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
  assign div_ge    = acc_q[WIDTH] | (div_shift >= {1'b0, opb_q});
  assign div_diff  = div_shift - {1'b0, opb_q};

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    state_d   = state_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          is_div_d  = md_is_div(op);
          neg_res_d = op_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          neg_rem_d = op_signed & md_is_div(op) & a_i[WIDTH-1];
          dz_d      = md_is_div(op) & (b_i == '0);
          acc_d     = '0;
          cnt_d     = CW'(WIDTH);
          opa_d     = a_abs;
          opb_d     = b_abs;
          if (dz_d) begin
            opa_d   = a_i;  // divide by zero returns the dividend untouched
            state_d = FINISH;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          acc_d = {{(WIDTH-1){1'b0}}, (div_ge ? div_diff : div_shift)};
          opa_d = {opa_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          opb_d = {1'b0, opb_q[WIDTH-1:1]};
        end
        if (cnt_d == '0) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          hi_d = opa_q;
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over everything: abort, drop any start, keep old results.
    if (flush_i) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH=32) with hand-computed results.
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst, start, flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .flush_i(flush),
    .busy_o (busy),
    .done_o (done),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input string tag);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
  endtask

  // lat counts cycles from the start cycle to the done cycle.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat,
                        input string tag);
    int lat;
    issue(o, x, y, tag);
    wait_done(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_busy_in_done"}, busy, 0);
  endtask

  // Watch for any done pulse over n cycles.
  task automatic watch_no_done(input int n, input string tag);
    logic saw;
    saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      saw = saw | done;
    end
    check({tag, "_no_done"}, saw, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    rst = 1'b0;
    tick();

    // Each run_op ends in the done cycle, so every next issue is back-to-back.
    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mult_neg");
    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 34, "multu");
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, "div_neg_dividend");
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, "div_neg_divisor");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, "div_minint");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 34, "divu_big");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34, "mult_minint");
    run_op(2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F, 34, "mult_negneg");
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 2, "div_zero");
    run_op(2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 2, "divu_zero");

    // done is a single pulse and results hold afterwards.
    tick();
    check("hold_done_low", done, 0);
    repeat (3) tick();
    check("hold_hi", hi, 32'h0000_1234);
    check("hold_lo", lo, 32'hFFFF_FFFF);

    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34, "divu");

    // Flush at RUN cycle 10.
    issue(2'b00, 32'd3, 32'd5, "flush_run");
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_run_busy", busy, 0);
    watch_no_done(40, "flush_run");
    check("flush_run_hi", hi, 32'd2);
    check("flush_run_lo", lo, 32'd14);

    // Flush together with start: start is dropped.
    op    = 2'b00;
    a     = 32'd3;
    b     = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", busy, 0);
    watch_no_done(40, "flush_start");
    check("flush_start_hi", hi, 32'd2);
    check("flush_start_lo", lo, 32'd14);

    // Flush while in FINISH: no done, results kept.
    issue(2'b00, 32'd3, 32'd5, "flush_finish");
    repeat (32) tick();
    check("flush_finish_pre_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_finish_busy", busy, 0);
    check("flush_finish_done", done, 0);
    watch_no_done(5, "flush_finish");
    check("flush_finish_hi", hi, 32'd2);
    check("flush_finish_lo", lo, 32'd14);

    // Start while busy is ignored; the in-flight MULTU 6*7 completes.
    issue(2'b01, 32'd6, 32'd7, "start_busy");
    repeat (5) tick();
    op    = 2'b11;
    a     = 32'd100;
    b     = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("start_busy_lat", lat, 34 - 6);
    check("start_busy_hi", hi, 32'd0);
    check("start_busy_lo", lo, 32'd42);

    // Reset mid-RUN clears all outputs on the next edge.
    issue(2'b00, 32'd3, 32'd5, "rst_mid");
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    rst = 1'b0;
    tick();
    run_op(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 34, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
